// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver. Scan and blink timing
// are clock-enables inside the clk_in domain; every output is registered.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 262144,
    parameter int GAP_CYCLES = 64,
    parameter int BLINK_DIV  = 33554432
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_END    = CW'(GAP_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The first edge after reset is edge 0 and leaves every counter at 0.
    logic            started;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      digit, digit_next;
    state_t          state, state_next;
    logic [BW-1:0]   blink_cnt, blink_cnt_next;
    logic            blink_phase, blink_phase_next;

    logic [3:0]      nib_l, nib_next;
    logic            dp_l, dp_l_next;
    logic            bl_l, bl_l_next;
    logic            bk_l, bk_l_next;

    logic [3:0]      an_next;
    logic [6:0]      seg_next;
    logic            dp_next;
    logic            dark;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            cnt         <= '0;
            digit       <= 2'd0;
            state       <= GAP;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            started     <= 1'b1;
            cnt         <= cnt_next;
            digit       <= digit_next;
            state       <= state_next;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end

    always_comb begin
        cnt_next         = cnt;
        digit_next       = digit;
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        if (started) begin
            if (cnt == SLOT_LAST) begin
                cnt_next   = '0;
                digit_next = digit + 2'd1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
            end
        end
    end

    // Slot FSM plus digit sampling on the GAP->ON edge.
    always_comb begin
        state_next = state;
        nib_next   = nib_l;
        dp_l_next  = dp_l;
        bl_l_next  = bl_l;
        bk_l_next  = bk_l;
        case (state)
            GAP: begin
                if (cnt_next == GAP_END) begin
                    state_next = ON;
                    nib_next   = value[{digit, 2'b00} +: 4];
                    dp_l_next  = dp_en[digit];
                    bl_l_next  = blink_mask[digit];
                    bk_l_next  = blank_mask[digit];
                end
            end
            ON: begin
                if (cnt_next == '0) begin
                    state_next = GAP;
                end
            end
            default: state_next = GAP;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            nib_l <= 4'h0;
            dp_l  <= 1'b0;
            bl_l  <= 1'b0;
            bk_l  <= 1'b0;
        end else begin
            nib_l <= nib_next;
            dp_l  <= dp_l_next;
            bl_l  <= bl_l_next;
            bk_l  <= bk_l_next;
        end
    end

    // Blink uses the phase as it stood before this edge.
    always_comb begin
        dark     = (state_next == GAP) || bk_l_next || (bl_l_next && blink_phase);
        an_next  = 4'b1111;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!dark) begin
            an_next  = ~(4'b0001 << digit_next);
            seg_next = hex_to_seg(nib_next);
            dp_next  = ~dp_l_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver using small scan/blink parameters;
// outputs are sampled on the falling edge after each counted rising edge.
module tb_seg7_scan_driver;

    logic        clk_in;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic [3:0]  blink_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests_run;
    int tests_failed;
    int edge_idx;

    logic [6:0] seg_tab [16];

    seg7_scan_driver #(
        .SCAN_DIV  (16),
        .GAP_CYCLES(4),
        .BLINK_DIV (128)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .value     (value),
        .dp_en     (dp_en),
        .blink_mask(blink_mask),
        .blank_mask(blank_mask),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_output(input string tag, input logic [3:0] exp_an,
                                input logic [6:0] exp_seg, input logic exp_dp);
        tests_run++;
        assert ({an, seg, dp} === {exp_an, exp_seg, exp_dp})
        else begin
            tests_failed++;
            $error("[TB] FAIL %s (edge %0d): an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   tag, edge_idx, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
    endtask

    // Leaves the bench at the falling edge just after rising edge k.
    task automatic adv(input int k);
        while (edge_idx < k) begin
            @(posedge clk_in);
            edge_idx++;
            @(negedge clk_in);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n    = 1'b1;
        edge_idx = -1;
    endtask

    task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] dpe,
                                  input logic [3:0] blm, input logic [3:0] bkm);
        value      = v;
        dp_en      = dpe;
        blink_mask = blm;
        blank_mask = bkm;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        tests_run    = 0;
        tests_failed = 0;
        edge_idx     = -1;
        rst_n        = 1'b0;
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000);

        // Reset state while rst_n is held low
        repeat (2) @(negedge clk_in);
        check_output("reset_hold", 4'b1111, 7'h7F, 1'b1);

        // Basic scan of 16'h1234
        apply_reset();
        adv(0);   check_output("t1_gap_e0",   4'b1111, 7'h7F, 1'b1);
        adv(3);   check_output("t1_gap_e3",   4'b1111, 7'h7F, 1'b1);
        adv(4);   check_output("t1_d0_on",    4'b1110, 7'h19, 1'b1);
        adv(15);  check_output("t1_d0_last",  4'b1110, 7'h19, 1'b1);
        adv(16);  check_output("t1_d1_gap",   4'b1111, 7'h7F, 1'b1);
        adv(19);  check_output("t1_d1_gap3",  4'b1111, 7'h7F, 1'b1);
        adv(20);  check_output("t1_d1_on",    4'b1101, 7'h30, 1'b1);
        adv(31);  check_output("t1_d1_last",  4'b1101, 7'h30, 1'b1);
        adv(36);  check_output("t1_d2_on",    4'b1011, 7'h24, 1'b1);
        adv(52);  check_output("t1_d3_on",    4'b0111, 7'h79, 1'b1);
        adv(63);  check_output("t1_d3_last",  4'b0111, 7'h79, 1'b1);
        adv(64);  check_output("t1_wrap_gap", 4'b1111, 7'h7F, 1'b1);
        adv(68);  check_output("t1_wrap_d0",  4'b1110, 7'h19, 1'b1);

        // Full hex sweep, one frame per digit value
        for (int h = 0; h < 16; h++) begin
            adv(128 + 64 * h);
            value = {4{h[3:0]}};
            for (int d = 0; d < 4; d++) begin
                adv(128 + 64 * h + 16 * d + 4);
                check_output($sformatf("t2_hex%0h_d%0d", h, d),
                             ~(4'b0001 << d), seg_tab[h], 1'b1);
            end
        end

        // Decimal points on digits 0 and 2
        adv(1152);
        apply_stimulus(16'h8888, 4'b0101, 4'b0000, 4'b0000);
        adv(1156); check_output("t3_d0_dp", 4'b1110, 7'h00, 1'b0);
        adv(1172); check_output("t3_d1_dp", 4'b1101, 7'h00, 1'b1);
        adv(1188); check_output("t3_d2_dp", 4'b1011, 7'h00, 1'b0);
        adv(1204); check_output("t3_d3_dp", 4'b0111, 7'h00, 1'b1);

        // Value change mid-slot is not seen until the next sample
        apply_stimulus(16'h0000, 4'b0000, 4'b0000, 4'b0000);
        apply_reset();
        adv(7);
        value = 16'hFFFF;
        adv(8);   check_output("t4_d0_hold",  4'b1110, 7'h40, 1'b1);
        adv(15);  check_output("t4_d0_hold2", 4'b1110, 7'h40, 1'b1);
        adv(20);  check_output("t4_d1_new",   4'b1101, 7'h0E, 1'b1);

        // Blink on digit 0, blank on digit 2
        apply_stimulus(16'h1234, 4'b0000, 4'b0001, 4'b0100);
        apply_reset();
        adv(4);   check_output("t5_d0_lit",    4'b1110, 7'h19, 1'b1);
        adv(20);  check_output("t5_d1_lit",    4'b1101, 7'h30, 1'b1);
        adv(36);  check_output("t5_d2_blank",  4'b1111, 7'h7F, 1'b1);
        adv(68);  check_output("t5_d0_lit2",   4'b1110, 7'h19, 1'b1);
        adv(132); check_output("t5_d0_dark",   4'b1111, 7'h7F, 1'b1);
        adv(143); check_output("t5_d0_dark2",  4'b1111, 7'h7F, 1'b1);
        adv(148); check_output("t5_d1_nblink", 4'b1101, 7'h30, 1'b1);
        adv(164); check_output("t5_d2_blank2", 4'b1111, 7'h7F, 1'b1);
        adv(196); check_output("t5_d0_dark3",  4'b1111, 7'h7F, 1'b1);
        adv(260); check_output("t5_d0_relit",  4'b1110, 7'h19, 1'b1);

        // Asynchronous reset in the middle of digit 2
        apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000);
        apply_reset();
        adv(37);  check_output("t6_pre_reset", 4'b1011, 7'h24, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("t6_async_reset", 4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk_in);
        rst_n    = 1'b1;
        edge_idx = -1;
        adv(0);   check_output("t6_gap_e0", 4'b1111, 7'h7F, 1'b1);
        adv(3);   check_output("t6_gap_e3", 4'b1111, 7'h7F, 1'b1);
        adv(4);   check_output("t6_d0_on",  4'b1110, 7'h19, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
